// File: rtl/dmem_responder_if.sv
// Dump stream bundle for dmem_responder.
// Valid/ready word stream plus sticky completion flag.
interface dmem_responder_if #(
  parameter int AW = 11
);
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [63:0]   dump_data;
  logic          dump_done;

  modport master (
    output dump_valid,
    output dump_addr,
    output dump_data,
    output dump_done,
    input  dump_ready
  );

  modport slave (
    input  dump_valid,
    input  dump_addr,
    input  dump_data,
    input  dump_done,
    output dump_ready
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: data memory on the MEM-stage bus, dumped on halt.
// Optional macro DMEM_STATS_EN adds rd_cnt/wr_cnt access counters.
module dmem_responder #(
  parameter int DEPTH = 1026,
  parameter int AW    = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [63:0]      mem_addr,
  input  logic             mem_rw,
  inout  wire  [63:0]      mem_data,
  input  logic             halt,
  dmem_responder_if.master dump
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]      rd_cnt,
  output logic [31:0]      wr_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DUMP,
    S_DONE
  } state_e;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [63:0]   mem [DEPTH];

  state_e        state_q;
  state_e        state_d;
  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;
  logic [63:0]   data_q;
  logic [63:0]   data_d;

  logic [AW-1:0] idx;
  logic          in_rng;
  logic [63:0]   rd_word;
  logic          wr_en;
  logic          load_c;
  logic [AW-1:0] nxt_c;
  logic          unused_addr;

  assign idx    = mem_addr[AW+2:3];
  assign in_rng = (idx <= LAST);

  assign unused_addr = ^{mem_addr[63:AW+3], mem_addr[2:0]};

  // Combinational load path; out-of-range words read as zero.
  always_comb begin
    rd_word = '0;
    if (in_rng) begin
      rd_word = mem[idx];
    end
  end

  assign mem_data = mem_rw ? 64'bz : rd_word;

  assign wr_en = (state_q == S_IDLE) && mem_rw && in_rng;

  // Storage array keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= mem_data;
    end
  end

  // Dump sequencer: next state, pointer and the next word to present.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    load_c  = 1'b0;
    nxt_c   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (halt) begin
          state_d = S_DUMP;
          ptr_d   = '0;
          nxt_c   = '0;
          load_c  = 1'b1;
        end
      end
      S_DUMP: begin
        if (dump.dump_ready) begin
          if (ptr_q == LAST) begin
            state_d = S_DONE;
          end else begin
            ptr_d  = ptr_q + AW'(1);
            nxt_c  = ptr_q + AW'(1);
            load_c = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
    // A store on the halt edge must be seen by the first dumped word.
    if (load_c) begin
      if (wr_en && (idx == nxt_c)) begin
        data_d = mem_data;
      end else begin
        data_d = mem[nxt_c];
      end
    end
  end

  // Dump state, pointer and registered data word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
    end
  end

  assign dump.dump_valid = (state_q == S_DUMP);
  assign dump.dump_done  = (state_q == S_DONE);
  assign dump.dump_addr  = ptr_q;
  assign dump.dump_data  = data_q;

`ifdef DMEM_STATS_EN
  logic [31:0] rd_cnt_q;
  logic [31:0] rd_cnt_d;
  logic [31:0] wr_cnt_q;
  logic [31:0] wr_cnt_d;
  logic        rd_hit;

  assign rd_hit = (state_q == S_IDLE) && !mem_rw && (mem_addr != '0);

  // Saturating access counters.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    if (rd_hit && (rd_cnt_q != '1)) begin
      rd_cnt_d = rd_cnt_q + 32'd1;
    end
    if (wr_en && (wr_cnt_q != '1)) begin
      wr_cnt_d = wr_cnt_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder.
// Random traffic checked against an array model of the memory.
module tb_dmem_responder;
  localparam int DEPTH = 1026;
  localparam int AW    = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] mem_addr = '0;
  logic        mem_rw = 1'b0;
  logic [63:0] wdata = '0;
  logic        halt = 1'b0;
  wire  [63:0] mem_data;
`ifdef DMEM_STATS_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;
`endif

  assign mem_data = mem_rw ? wdata : 64'bz;

  dmem_responder_if #(.AW(AW)) dif ();

  dmem_responder #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .mem_addr(mem_addr),
    .mem_rw  (mem_rw),
    .mem_data(mem_data),
    .halt    (halt),
    .dump    (dif)
`ifdef DMEM_STATS_EN
    ,
    .rd_cnt  (rd_cnt),
    .wr_cnt  (wr_cnt)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] model [DEPTH];

  function automatic int word_of(input logic [63:0] a);
    longint unsigned w;
    w = (longint'(a) / 8) % 2048;
    return int'(w);
  endfunction

  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    int w;
    w = word_of(a);
    if (w < DEPTH) return model[w];
    return 64'd0;
  endfunction

  task automatic do_store(input logic [63:0] a, input logic [63:0] v);
    int w;
    @(negedge clk);
    halt     = 1'b0;
    mem_rw   = 1'b1;
    mem_addr = a;
    wdata    = v;
    @(posedge clk);
    w = word_of(a);
    if (w < DEPTH) model[w] = v;
  endtask

  task automatic do_load(input logic [63:0] a, input string nm);
    logic [63:0] exp;
    @(negedge clk);
    halt     = 1'b0;
    mem_rw   = 1'b0;
    mem_addr = a;
    #1;
    exp = ref_rd(a);
    vectors++;
    if (mem_data !== exp) begin
      miscompares++;
      $display("FAIL %s addr=%0d: got %h expected %h", nm, a, mem_data, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    mem_rw         = 1'b0;
    mem_addr       = '0;
    halt           = 1'b0;
    dif.dump_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_idle_outputs(input string nm);
    vectors++;
    if (dif.dump_valid !== 1'b0 || dif.dump_addr !== '0 ||
        dif.dump_data !== '0 || dif.dump_done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got v=%b a=%0d d=%h done=%b expected 0,0,0,0",
               nm, dif.dump_valid, dif.dump_addr, dif.dump_data,
               dif.dump_done);
    end
  endtask

  // Consume dump words until stop_at accepted; mode 0 = 1,0,0 ready, 1 = random.
  task automatic check_dump(input int mode, input int stop_at);
    int          exp_ptr;
    int          cyc;
    logic        rdy;
    logic        prev_rdy;
    logic [63:0] prev_data;
    exp_ptr   = 0;
    cyc       = 0;
    prev_rdy  = 1'b1;
    prev_data = '0;
    while (exp_ptr < stop_at && cyc < 6 * DEPTH) begin
      @(negedge clk);
      if (mode == 0) rdy = (cyc % 3 == 0);
      else rdy = 1'($urandom_range(0, 1));
      dif.dump_ready = rdy;
      #1;
      vectors++;
      if (dif.dump_valid !== 1'b1 || dif.dump_done !== 1'b0 ||
          dif.dump_addr !== AW'(exp_ptr) ||
          dif.dump_data !== model[exp_ptr]) begin
        miscompares++;
        $display("FAIL dump_word: got v=%b done=%b a=%0d d=%h expected 1,0,%0d,%h",
                 dif.dump_valid, dif.dump_done, dif.dump_addr,
                 dif.dump_data, exp_ptr, model[exp_ptr]);
      end
      if (!prev_rdy) begin
        vectors++;
        if (dif.dump_data !== prev_data) begin
          miscompares++;
          $display("FAIL dump_hold: got %h expected %h",
                   dif.dump_data, prev_data);
        end
      end
      prev_rdy  = rdy;
      prev_data = dif.dump_data;
      if (rdy) exp_ptr++;
      cyc++;
    end
    if (exp_ptr < stop_at) begin
      miscompares++;
      $display("FAIL dump_timeout: got %0d words expected %0d",
               exp_ptr, stop_at);
    end
  endtask

  task automatic test_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_state");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      do_store(64'(i * 8), {$urandom, $urandom});
    end
  endtask

  task automatic test_store_load();
    do_store(64'd16, 64'hDEAD_BEEF_0000_0001);
    do_load(64'd16, "store_load");
  endtask

  task automatic test_boundary();
    do_store(64'd8207, 64'h1025_1025_A5A5_5A5A);
    do_store(64'd8216, 64'hFFFF_0000_FFFF_0000);
    do_load(64'd8207, "top_word");
    do_load(64'd8216, "out_of_range");
    do_load(64'd8200, "top_word_aligned");
  endtask

  task automatic test_random_access();
    logic [63:0] a;
    for (int i = 0; i < 40; i++) begin
      a = 64'($urandom_range(0, 16383));
      if ($urandom_range(0, 1) == 1) begin
        do_store(a, {$urandom, $urandom});
      end
      do_load(a, "rand_access");
      do_load(64'($urandom_range(0, 16383)), "rand_load");
    end
  endtask

  task automatic test_halt_store_dump();
    logic [63:0] old4;
    old4 = model[4];
    @(negedge clk);
    mem_rw   = 1'b1;
    mem_addr = 64'd24;
    wdata    = 64'd5;
    halt     = 1'b1;
    @(posedge clk);
    model[3] = 64'd5;
    #1;
    mem_addr = 64'd32;
    wdata    = 64'hBAD0_BAD0_BAD0_BAD0;
    check_dump(0, DEPTH);
    @(negedge clk);
    dif.dump_ready = 1'b1;
    #1;
    vectors++;
    if (dif.dump_valid !== 1'b0 || dif.dump_done !== 1'b1) begin
      miscompares++;
      $display("FAIL dump_done: got v=%b done=%b expected 0,1",
               dif.dump_valid, dif.dump_done);
    end
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (dif.dump_valid !== 1'b0 || dif.dump_done !== 1'b1) begin
      miscompares++;
      $display("FAIL done_sticky: got v=%b done=%b expected 0,1",
               dif.dump_valid, dif.dump_done);
    end
    vectors++;
    if (model[4] !== old4) begin
      miscompares++;
      $display("FAIL model_word4: got %h expected %h", model[4], old4);
    end
    do_load(64'd32, "blocked_store");
    do_load(64'd24, "halt_cycle_store");
  endtask

  task automatic test_reset_mid_dump();
    apply_reset();
    @(negedge clk);
    halt = 1'b1;
    @(posedge clk);
    check_dump(1, 500);
    @(negedge clk);
    dif.dump_ready = 1'b0;
    halt           = 1'b0;
    #1;
    vectors++;
    if (dif.dump_valid !== 1'b1 || dif.dump_addr !== AW'(500)) begin
      miscompares++;
      $display("FAIL ptr_500: got v=%b a=%0d expected 1,500",
               dif.dump_valid, dif.dump_addr);
    end
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_dump_reset");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_idle_outputs("after_reset_idle");
    @(negedge clk);
    halt = 1'b1;
    @(posedge clk);
    check_dump(1, DEPTH);
    @(negedge clk);
    halt = 1'b0;
    #1;
    vectors++;
    if (dif.dump_done !== 1'b1) begin
      miscompares++;
      $display("FAIL redump_done: got %b expected 1", dif.dump_done);
    end
    do_load(64'd16, "kept_after_reset");
  endtask

`ifdef DMEM_STATS_EN
  task automatic test_stats();
    apply_reset();
    do_store(64'd8, {$urandom, $urandom});
    do_store(64'd40, {$urandom, $urandom});
    do_store(64'd800, {$urandom, $urandom});
    do_load(64'd8, "stats_load");
    do_load(64'd40, "stats_load");
    do_load(64'd800, "stats_load");
    do_load(64'd16, "stats_load");
    @(negedge clk);
    mem_addr = '0;
    mem_rw   = 1'b0;
    #1;
    vectors++;
    if (wr_cnt !== 32'd3 || rd_cnt !== 32'd4) begin
      miscompares++;
      $display("FAIL stats_count: got wr=%0d rd=%0d expected 3,4",
               wr_cnt, rd_cnt);
    end
    apply_reset();
    #1;
    vectors++;
    if (wr_cnt !== 32'd0 || rd_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL stats_reset: got wr=%0d rd=%0d expected 0,0",
               wr_cnt, rd_cnt);
    end
  endtask
`endif

  initial begin
    dif.dump_ready = 1'b0;
    test_reset();
    test_fill();
    test_store_load();
    test_boundary();
    test_random_access();
`ifdef DMEM_STATS_EN
    test_stats();
`endif
    test_halt_store_dump();
    test_reset_mid_dump();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by 1000000");
    $fatal(1, "watchdog expired");
  end

endmodule
